// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared state type and constants for the GMII UDP transmit scheduler.
package udp_tx_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_e;
   localparam int SEQ_W         = 16;
   localparam int LEN_W         = 16;
   localparam int PKT_BYTES_DEF = 1440;
endpackage

// File: rtl/udp_tx_gap_timer.sv
// udp_tx_gap_timer: loadable down-counter; tc is high while the count sits at zero.
module udp_tx_gap_timer #(
   parameter int W = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tc = cnt_q == '0;
   always_comb cnt_d = load ? load_val : (en && !tc) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: starts GMII UDP packets from the video FIFO level, stamps sequence numbers, enforces IPG and done timeout.
// Define UDP_TX_SEQ_FRAME_RESET_EN to restart pkt_seq at 0 for every frame.
module udp_tx_scheduler
   import udp_tx_pkg::*;
#(
   parameter int PKT_BYTES      = PKT_BYTES_DEF,
   parameter int FIFO_AW        = 12,
   parameter int IPG_CYCLES     = 24,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic             GMII_GTXCLK,
   input  logic             rst_n,
   input  logic [FIFO_AW:0] fifo_level,
   input  logic             frame_eof,
   input  logic             send_done,
   output logic             send_start,
   output logic [LEN_W-1:0] send_len,
   output logic [SEQ_W-1:0] pkt_seq,
   output logic             busy,
   output logic             timeout_err
);
   localparam int TW = $clog2((TIMEOUT_CYCLES > IPG_CYCLES ? TIMEOUT_CYCLES : IPG_CYCLES) + 1);
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(PKT_BYTES);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [SEQ_W-1:0] seq_q, seq_d, seq_gap, seq_idle;
   logic             tail_q, tail_d, terr_q, terr_d;
   logic             tmr_load, tmr_tc, lvl_full, lvl_zero;
   logic [TW-1:0]    tmr_val;

   assign lvl_full = fifo_level >= FULL_LVL;
   assign lvl_zero = fifo_level == '0;

`ifdef UDP_TX_SEQ_FRAME_RESET_EN
   // Remembers whether the packet in flight closes a frame.
   logic tpkt_q, tpkt_d;
   always_comb tpkt_d = (state_q == IDLE) ? !lvl_full : tpkt_q;
   always_ff @(posedge GMII_GTXCLK or negedge rst_n)
      if (!rst_n) tpkt_q <= 1'b0;
      else        tpkt_q <= tpkt_d;
   assign seq_gap  = tpkt_q ? '0 : seq_q + 1'b1;
   assign seq_idle = (tail_q && !frame_eof) ? '0 : seq_q;
`else
   assign seq_gap  = seq_q + 1'b1;
   assign seq_idle = seq_q;
`endif

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      seq_d    = seq_q;
      tail_d   = tail_q | frame_eof;
      terr_d   = terr_q;
      tmr_load = 1'b0;
      tmr_val  = TW'(IPG_CYCLES - 1);
      case (state_q)
         IDLE: begin
            if (lvl_full) begin
               state_d = START;
               len_d   = LEN_W'(PKT_BYTES);
            end else if (tail_q && !lvl_zero) begin
               state_d = START;
               len_d   = LEN_W'(fifo_level);
               tail_d  = frame_eof;
            end else if (lvl_zero) begin
               seq_d  = seq_idle;
               tail_d = frame_eof;
            end
         end
         START: begin
            state_d  = WAIT_DONE;
            tmr_load = 1'b1;
            tmr_val  = TW'(TIMEOUT_CYCLES - 1);
         end
         WAIT_DONE:
            if (send_done || tmr_tc) begin
               state_d  = GAP;
               seq_d    = seq_gap;
               terr_d   = terr_q | !send_done;
               tmr_load = 1'b1;
            end
         default:
            if (tmr_tc) state_d = IDLE;
      endcase
   end

   always_ff @(posedge GMII_GTXCLK or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         seq_q   <= '0;
         tail_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         seq_q   <= seq_d;
         tail_q  <= tail_d;
         terr_q  <= terr_d;
      end

   udp_tx_gap_timer #(.W(TW)) u_timer (
      .clk      (GMII_GTXCLK),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (busy),
      .tc       (tmr_tc)
   );

   assign send_start  = state_q == START;
   assign busy        = state_q != IDLE;
   assign send_len    = len_q;
   assign pkt_seq     = seq_q;
   assign timeout_err = terr_q;
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb_udp_tx_scheduler: directed bench for udp_tx_scheduler with a sender model that pulses send_done.
module tb_udp_tx_scheduler;
`ifdef UDP_TX_SEQ_FRAME_RESET_EN
   localparam bit FR = 1'b1;
`else
   localparam bit FR = 1'b0;
`endif
   logic        clk = 1'b0, rst_n = 1'b0, frame_eof = 1'b0, send_done = 1'b0;
   logic [12:0] fifo_level = '0;
   logic        send_start, busy, timeout_err;
   logic [15:0] send_len, pkt_seq;
   int cyc = 0, n_cmp = 0, n_err = 0, done_dly = 100, done_at = -1, exp_seq = 0, c0 = 0, s = 0;
   int st_cyc[$], st_len[$], st_seq[$];

   always #4 clk = ~clk;

   udp_tx_scheduler dut (
      .GMII_GTXCLK (clk),
      .rst_n       (rst_n),
      .fifo_level  (fifo_level),
      .frame_eof   (frame_eof),
      .send_done   (send_done),
      .send_start  (send_start),
      .send_len    (send_len),
      .pkt_seq     (pkt_seq),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Start monitor; the sender answers on the done_dly-th clock counting the start clock as the first.
   always @(negedge clk)
      if (send_start) begin
         st_cyc.push_back(cyc);
         st_len.push_back(int'(send_len));
         st_seq.push_back(int'(pkt_seq));
         done_at = (done_dly != 0) ? cyc + done_dly - 1 : -1;
      end

   always @(posedge clk) begin
      #1;
      send_done = (done_dly != 0) && (cyc == done_at);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) tick();
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      int k = 0;
      while (st_cyc.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(tag, st_cyc.size(), n);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy && k < budget) begin
         tick();
         k++;
      end
      check(tag, int'(busy), 0);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_start", int'(send_start), 0);
      check("rst_len", int'(send_len), 0);
      check("rst_seq", int'(pkt_seq), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_terr", int'(timeout_err), 0);
      rst_n = 1'b1;
      tick();
      // Back-to-back full packets
      c0 = cyc;
      fifo_level = 13'd1440;
      wait_starts(3, 400, "t1_starts");
      fifo_level = '0;
      check("t1_latency", st_cyc[0] - c0, 1);
      for (int i = 0; i < 3; i++) begin
         check("t1_len", st_len[i], 1440);
         check("t1_seq", st_seq[i], i);
      end
      check("t1_spacing01", st_cyc[1] - st_cyc[0], 125);
      check("t1_spacing12", st_cyc[2] - st_cyc[1], 125);
      wait_idle(200, "t1_idle");
      check("t1_seq_after", int'(pkt_seq), 3);
      exp_seq = 3;
      // Short frame tail
      tick();
      c0 = cyc;
      fifo_level = 13'd500;
      frame_eof = 1'b1;
      tick();
      frame_eof = 1'b0;
      wait_starts(4, 50, "t2_start");
      fifo_level = '0;
      check("t2_latency", st_cyc[3] - c0, 2);
      check("t2_len", st_len[3], 500);
      check("t2_seq", st_seq[3], exp_seq);
      wait_idle(200, "t2_idle");
      exp_seq = FR ? 0 : exp_seq + 1;
      check("t2_seq_after", int'(pkt_seq), exp_seq);
      fifo_level = 13'd10;
      repeat (60) tick();
      check("t2_tail_cleared", st_cyc.size(), 4);
      fifo_level = '0;
      // Two full packets then a 120-byte tail
      tick();
      fifo_level = 13'd3000;
      frame_eof = 1'b1;
      tick();
      frame_eof = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_starts(5 + i, 400, "t3_start");
         fifo_level = fifo_level - 13'(st_len[4 + i]);
      end
      check("t3_len0", st_len[4], 1440);
      check("t3_len1", st_len[5], 1440);
      check("t3_len2", st_len[6], 120);
      for (int i = 0; i < 3; i++) check("t3_seq", st_seq[4 + i], exp_seq + i);
      wait_idle(200, "t3_idle");
      exp_seq = FR ? 0 : exp_seq + 3;
      check("t3_seq_after", int'(pkt_seq), exp_seq);
      // Frame ending exactly on a packet boundary
      tick();
      fifo_level = 13'd1440;
      frame_eof = 1'b1;
      tick();
      frame_eof = 1'b0;
      wait_starts(8, 10, "t4_start");
      fifo_level = '0;
      check("t4_len", st_len[7], 1440);
      check("t4_seq", st_seq[7], exp_seq);
      wait_idle(200, "t4_idle");
      tick();
      exp_seq = FR ? 0 : exp_seq + 1;
      check("t4_seq_after", int'(pkt_seq), exp_seq);
      fifo_level = 13'd10;
      repeat (60) tick();
      check("t4_tail_cleared", st_cyc.size(), 8);
      fifo_level = '0;
      // Sender never answers
      done_dly = 0;
      tick();
      fifo_level = 13'd1440;
      wait_starts(9, 10, "t5_start");
      s = st_cyc[8];
      done_dly = 100;
      check("t5_seq", st_seq[8], exp_seq);
      wait_cyc(s + 20000);
      check("t5_err_before", int'(timeout_err), 0);
      check("t5_busy_wait", int'(busy), 1);
      tick();
      check("t5_err_set", int'(timeout_err), 1);
      check("t5_seq_adv", int'(pkt_seq), (exp_seq + 1) & 16'hFFFF);
      wait_starts(10, 100, "t5_restart");
      fifo_level = '0;
      check("t5_restart_at", st_cyc[9] - s, 20026);
      check("t5_restart_seq", st_seq[9], (exp_seq + 1) & 16'hFFFF);
      wait_idle(200, "t5_idle");
      check("t5_err_sticky", int'(timeout_err), 1);
      // Sequence wrap
      tick();
      force dut.seq_q = 16'hFFFF;
      tick();
      release dut.seq_q;
      tick();
      check("t6_preset", int'(pkt_seq), 16'hFFFF);
      fifo_level = 13'd1440;
      wait_starts(11, 10, "t6_start0");
      wait_starts(12, 200, "t6_start1");
      fifo_level = '0;
      check("t6_seq_ffff", st_seq[10], 16'hFFFF);
      check("t6_seq_wrap", st_seq[11], 0);
      wait_idle(200, "t6_idle");
      // Reset in the middle of a packet
      tick();
      fifo_level = 13'd1440;
      wait_starts(13, 10, "t7_start");
      repeat (10) tick();
      check("t7_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("t7_rst_start", int'(send_start), 0);
      check("t7_rst_len", int'(send_len), 0);
      check("t7_rst_seq", int'(pkt_seq), 0);
      check("t7_rst_busy", int'(busy), 0);
      check("t7_rst_terr", int'(timeout_err), 0);
      repeat (3) tick();
      check("t7_no_start_in_rst", st_cyc.size(), 13);
      rst_n = 1'b1;
      wait_starts(14, 10, "t7_restart");
      fifo_level = '0;
      check("t7_restart_seq", st_seq[13], 0);
      check("t7_restart_len", st_len[13], 1440);
      wait_idle(200, "t7_idle");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/udp_tx_scheduler.md
Name: udp_tx_scheduler

Overview:
- Sequences the GMII UDP sender from the video FIFO read side, all in the 125 MHz GMII transmit domain.
- Decides when a packet starts and its payload length (full packet, or short tail at end of frame).
- Stamps each packet with a 16-bit sequence number.
- Enforces a minimum inter-packet gap and recovers from a sender that never signals done.

Parameters:
PKT_BYTES, 1440, full payload bytes per packet (excludes 2-byte sequence header)
FIFO_AW, 12, FIFO read-side level width minus one; level port is FIFO_AW+1 bits
IPG_CYCLES, 24, minimum idle clocks between send_done and next send_start (≥1)
TIMEOUT_CYCLES, 20000, max clocks in WAIT_DONE before forced abort

Ports:
GMII_GTXCLK  in  1  125 MHz clock
rst_n  in  1  asynchronous active-low reset
fifo_level  in  FIFO_AW+1  bytes currently readable in FIFO
frame_eof  in  1  one-clock pulse: last byte of a frame is in the FIFO
send_done  in  1  one-clock pulse from sender: packet fully transmitted
send_start  out  1  one-clock pulse: begin packet
send_len  out  16  payload bytes for this packet, stable from send_start to send_done
pkt_seq  out  16  sequence number for this packet, stable with send_len
busy  out  1  high from send_start through end of GAP
timeout_err  out  1  sticky; set on WAIT_DONE timeout, cleared only by reset

Behaviour:
- Reset values: send_start=0, send_len=0, pkt_seq=0, busy=0, timeout_err=0, tail_pend=0, state=IDLE.
- Reset is asynchronous; mid-packet reset returns to IDLE immediately with no start pulse issued.
- IDLE transitions:
  - fifo_level ≥ PKT_BYTES → START, len=PKT_BYTES.
  - Otherwise, if tail_pend=1 and fifo_level>0 → START, len=fifo_level (sampled that cycle).
  - Otherwise stay in IDLE.
  - A full packet has priority over the tail.
- tail_pend:
  - Set by frame_eof in any state.
  - Cleared when a tail packet starts.
  - Also cleared when fifo_level==0 while in IDLE (the frame ended exactly on a packet boundary).
  - frame_eof and the tail-clear condition in the same cycle: set wins.
- START:
  - Registers send_len and pkt_seq, which appear the same cycle send_start=1.
  - Exactly one cycle, then → WAIT_DONE.
  - Latency: 1 clock from the qualifying IDLE condition to the send_start pulse.
- WAIT_DONE:
  - Timeout counter increments each clock.
  - send_done → GAP.
  - Counter reaching TIMEOUT_CYCLES-1 → timeout_err=1, → GAP.
  - send_done and timeout in the same cycle: treat as done (no error).
- GAP:
  - Counts IPG_CYCLES clocks, then → IDLE.
  - pkt_seq increments (16-bit wrap, 0xFFFF→0x0000) on GAP entry, both after done and after timeout.
- send_done outside WAIT_DONE is ignored.
- busy = (state != IDLE).
- send_len is never 0. A tail never exceeds PKT_BYTES: in that case the full-packet path is taken and tail_pend is kept.

Optional Feature:
- Macro: UDP_TX_SEQ_FRAME_RESET_EN.
- Defined: pkt_seq returns to 0 on GAP entry after a tail packet (or after a boundary-aligned frame_eof clear), so every frame starts at sequence 0.
- Undefined: pkt_seq free-runs and wraps only at 16 bits.

Decomposition:
- Package udp_tx_pkg holds:
  - state enum {IDLE, START, WAIT_DONE, GAP};
  - SEQ_W=16 and LEN_W=16 constants;
  - the default PKT_BYTES.
- One sub-module is natural: udp_tx_gap_timer, a loadable down-counter shared by the WAIT_DONE timeout and the GAP count. It takes load value, enable and terminal-count output.

Test Plan:
- fifo_level held at 1440, send_done 100 clocks after each start → send_start pulses with send_len=1440, pkt_seq 0,1,2; start-to-start spacing = 1+100+24 clocks.
- fifo_level=500, frame_eof pulse, no other data → one packet with send_len=500, tail_pend cleared, then no further starts.
- fifo_level=3000 with frame_eof → two 1440 packets, then a tail of 120 bytes; sequence increments each time.
- send_done never arrives → after 20000 clocks timeout_err=1, pkt_seq advances, next packet starts after GAP.
- pkt_seq preset to 0xFFFF by running 65535 packets (or forcing) → next packet pkt_seq=0x0000. With UDP_TX_SEQ_FRAME_RESET_EN, the first packet after a tail has pkt_seq=0.
- rst_n asserted during WAIT_DONE → all outputs at reset values asynchronously; after release, next start carries pkt_seq=0.
